// File: rtl/ts_mux_pkg.sv
// Shared constants and types for the 4-input MPEG2-TS output mux scheduler.
package ts_mux_pkg;

  localparam int          TS_PKT_LEN  = 188;
  localparam int          N_TS_PORTS  = 4;
  // PID carried by the null packets the downstream generator emits.
  localparam logic [12:0] TS_NULL_PID = 13'h1FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    NULL = 2'd2
  } ts_state_e;

  function automatic logic [N_TS_PORTS-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/ts_mux_scheduler_wrr_pick.sv
// Rotating-priority picker: first eligible port after last_grant, wrapping.
module wrr_pick
  import ts_mux_pkg::*;
(
  input  logic [N_TS_PORTS-1:0] eligible,
  input  logic [1:0]            last_grant,
  output logic                  found,
  output logic [1:0]            idx
);

  // Scan lowest to highest priority; the last hit (nearest after last_grant) wins.
  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    for (int k = N_TS_PORTS; k >= 1; k--) begin
      if (eligible[last_grant + 2'(k)]) begin
        found = 1'b1;
        idx   = last_grant + 2'(k);
      end
    end
  end

endmodule

// File: rtl/ts_mux_scheduler.sv
// Weighted round-robin packet scheduler for the 4-input TS output mux.
// Grants whole packets, tracks per-port credits, fills idle slots with null packets.
module ts_mux_scheduler
  import ts_mux_pkg::*;
#(
  parameter int PKT_LEN = TS_PKT_LEN,
  parameter int W_BITS  = 4,
  parameter bit NULL_EN = 1'b1
) (
  input  logic                         clk2,
  input  logic                         rst_n,
  input  logic                         byte_tick,
  input  logic [N_TS_PORTS-1:0]        req,
  input  logic [N_TS_PORTS*W_BITS-1:0] weights,
  output logic [N_TS_PORTS-1:0]        valid,
  output logic [1:0]                   mux_ctrl,
  output logic                         pkt_start,
  output logic                         pkt_end,
  output logic                         null_active,
  output logic                         underrun
);

  localparam int CW = $clog2(PKT_LEN);

  ts_state_e                           state_q, state_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic [1:0]                          last_q, last_d;
  logic [1:0]                          mux_q, mux_d;
  logic [N_TS_PORTS-1:0][W_BITS-1:0]   cred_q, cred_d;
  logic [N_TS_PORTS-1:0]               req_q;
  logic                                start_q, start_d;
  logic                                ur_q, ur_d;

  logic [N_TS_PORTS-1:0][W_BITS-1:0]   wt;
  logic [N_TS_PORTS-1:0]               wt_nz, eligible, want;
  logic                                found;
  logic [1:0]                          pick;
  logic                                last_byte;

  assign wt        = weights;
  assign want      = req & wt_nz;
  assign last_byte = byte_tick && (cnt_q == CW'(PKT_LEN - 1));

  for (genvar i = 0; i < N_TS_PORTS; i++) begin : g_port
    assign wt_nz[i]    = |wt[i];
    assign eligible[i] = req[i] & wt_nz[i] & (|cred_q[i]);
  end

  wrr_pick u_pick (
    .eligible   (eligible),
    .last_grant (last_q),
    .found      (found),
    .idx        (pick)
  );

  // Next-state: grant beats reload beats null insertion; packets always run to completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    mux_d   = mux_q;
    cred_d  = cred_q;
    start_d = 1'b0;
    ur_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SEND;
          last_d  = pick;
          mux_d   = pick;
          start_d = 1'b1;
          cnt_d   = '0;
        end else if (|want) begin
          // Every weighted requester is out of credit: refill all, pick next cycle.
          cred_d = wt;
        end else if (NULL_EN && byte_tick) begin
          state_d = NULL;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (req_q[last_q] && !req[last_q]) ur_d = 1'b1;
        if (byte_tick) begin
          if (last_byte) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (|cred_q[last_q]) cred_d[last_q] = cred_q[last_q] - 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      NULL: begin
        if (byte_tick) begin
          if (last_byte) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and pulse registers; reset drops any packet in flight.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      mux_q   <= 2'd0;
      cred_q  <= '0;
      req_q   <= '0;
      start_q <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      mux_q   <= mux_d;
      cred_q  <= cred_d;
      req_q   <= req;
      start_q <= start_d;
      ur_q    <= ur_d;
    end
  end

  assign valid       = (state_q == SEND) ? onehot4(last_q) : '0;
  assign mux_ctrl    = mux_q;
  assign pkt_start   = start_q;
  assign pkt_end     = (state_q == SEND) && last_byte;
  assign null_active = (state_q == NULL);
  assign underrun    = ur_q;

endmodule

// File: tb/tb_ts_mux_scheduler.sv
// Scoreboard bench: packet-level WRR model predicts grants, negedge monitor checks them.
module tb_ts_mux_scheduler;

  localparam int PL = 188;

  logic        clk2 = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_tick = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [15:0] weights = 16'h0;
  logic [3:0]  valid;
  logic [1:0]  mux_ctrl;
  logic        pkt_start, pkt_end, null_active, underrun;

  ts_mux_scheduler #(.PKT_LEN(PL), .W_BITS(4), .NULL_EN(1'b1)) dut (
    .clk2        (clk2),
    .rst_n       (rst_n),
    .byte_tick   (byte_tick),
    .req         (req),
    .weights     (weights),
    .valid       (valid),
    .mux_ctrl    (mux_ctrl),
    .pkt_start   (pkt_start),
    .pkt_end     (pkt_end),
    .null_active (null_active),
    .underrun    (underrun)
  );

  always #5 clk2 = ~clk2;

  typedef struct {
    int port;
    int gap;   // idle cycles before the grant; 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0;
  int   tick_per = 3;
  bit   tb_done = 0;
  int   ur_cnt = 0, exp_ur = 0, nulls_done = 0;

  // reference model state
  int   m_cred[4], m_w[4], m_last;
  bit   m_first;

  function automatic void chk(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, expv);
    end
  endfunction

  task automatic model_reset(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      m_cred[i] = 0;
      m_w[i]    = int'(w[i*4 +: 4]);
    end
    m_last  = 3;
    m_first = 1;
  endtask

  // Next packet owner for a held request mask; refills credits when nobody can go.
  task automatic model_grant(input logic [3:0] rq);
    int   p, rl;
    exp_t e;
    p  = -1;
    rl = 0;
    for (int pass = 0; pass < 2 && p < 0; pass++) begin
      for (int k = 1; k <= 4 && p < 0; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (rq[c] && m_w[c] > 0 && m_cred[c] > 0) p = c;
      end
      if (p < 0) begin
        for (int i = 0; i < 4; i++) m_cred[i] = m_w[i];
        rl++;
      end
    end
    if (p >= 0) begin
      m_cred[p]--;
      m_last = p;
      e.port = p;
      e.gap  = m_first ? 0 : 1 + rl;
      m_first = 0;
      exp_q.push_back(e);
    end
  endtask

  // byte_tick: one cycle high, period tick_per cycles (0 = random 2..4)
  initial begin
    int p;
    while (!tb_done) begin
      @(posedge clk2); #1 byte_tick = 1'b1;
      @(posedge clk2); #1 byte_tick = 1'b0;
      p = (tick_per == 0) ? int'($urandom_range(4, 2)) : tick_per;
      repeat (p - 2) @(posedge clk2);
    end
  end

  // monitor
  initial begin
    exp_t       e;
    logic [3:0] prev_valid, oh;
    logic       prev_null;
    bit         in_pkt, in_null, held_ok, null_clean;
    int         cur, ticks, nticks, idle_cnt;
    prev_valid = 0; prev_null = 0; in_pkt = 0; in_null = 0;
    held_ok = 0; null_clean = 0; cur = 0; ticks = 0; nticks = 0; idle_cnt = 0;
    forever begin
      @(negedge clk2);
      if (!rst_n) begin
        in_pkt = 0; in_null = 0; idle_cnt = 0; prev_valid = 0; prev_null = 0;
      end else begin
        if (pkt_start || (valid != 0 && prev_valid == 0)) begin
          chk("pkt_start", pkt_start, 1);
          chk("valid_rise", prev_valid, 0);
          cur = int'(mux_ctrl);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_grant: got port %0d, required no grant", mux_ctrl);
          end else begin
            e = exp_q.pop_front();
            chk("grant_port", mux_ctrl, e.port);
            chk("grant_onehot", valid, 64'd1 << e.port);
            if (e.gap > 0) chk("idle_gap", idle_cnt, e.gap);
            cur = e.port;
          end
          in_pkt = 1; ticks = 0; held_ok = 1; idle_cnt = 0;
        end
        if (in_pkt) begin
          oh = 4'b0001 << cur;
          if (valid != oh) held_ok = 0;
          if (byte_tick) ticks++;
          if (pkt_end) begin
            chk("pkt_len", ticks, PL);
            chk("valid_held", held_ok, 1);
            in_pkt = 0; idle_cnt = 0;
          end
        end else if (pkt_end) begin
          total++; bad++;
          $display("FAIL stray_pkt_end: got pkt_end=1, required 0");
        end
        if (null_active && !prev_null) begin
          in_null = 1; nticks = 0; null_clean = 1;
        end
        if (in_null && null_active) begin
          if (byte_tick) nticks++;
          if (valid != 0 || pkt_start || pkt_end) null_clean = 0;
        end
        if (!null_active && prev_null && in_null) begin
          chk("null_len", nticks, PL);
          chk("null_clean", null_clean, 1);
          nulls_done++; in_null = 0; idle_cnt = 0;
        end
        if (underrun) ur_cnt++;
        if (valid == 0 && !null_active) idle_cnt++;
        prev_valid = valid; prev_null = null_active;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset(input logic [15:0] w, input logic [3:0] rq);
    @(posedge clk2); #1;
    rst_n = 1'b0;
    exp_q.delete();
    weights = w;
    req = rq;
    model_reset(w);
    repeat (2) @(posedge clk2);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk2); n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d grants outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_pkt_end(input int limit);
    int n = 0;
    do begin
      @(negedge clk2); n++;
    end while (!pkt_end && n < limit);
    if (!pkt_end) begin
      total++; bad++;
      $display("FAIL pkt_end_timeout: got no pkt_end in %0d cycles, required one", limit);
    end
  endtask

  // Drop requests in the idle cycle after a packet, before the next pick.
  task automatic quiesce();
    @(posedge clk2); #1 req = 4'b0;
  endtask

  task automatic count_ticks(input int nt);
    int c = 0, n = 0;
    while (c < nt && n < 10 * nt + 10) begin
      @(negedge clk2); n++;
      if (byte_tick) c++;
    end
  endtask

  task automatic run_phase(input logic [15:0] w, input logic [3:0] rq, input int npk, input int tp);
    tick_per = tp;
    apply_reset(w, rq);
    for (int n = 0; n < npk; n++) model_grant(rq);
    wait_drain(npk * 1000);
    wait_pkt_end(1000);
    quiesce();
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  rq;
    int          nd, lat, n;
    bit          seen;

    // equal weights, everyone requesting, tick every 4 cycles
    run_phase(16'h1111, 4'b1111, 5, 4);
    // port0=3, port1=1, port2 requests with weight 0; the rotation carries on
    // from the last grant across the refill, so round two opens on port 1
    run_phase(16'h0013, 4'b0111, 8, 0);

    for (int ph = 0; ph < 4; ph++) begin
      int i;
      w  = 16'h0;
      for (int k = 0; k < 4; k++) w[k*4 +: 4] = 4'($urandom_range(3, 0));
      rq = 4'($urandom_range(15, 0));
      i  = int'($urandom_range(3, 0));
      rq[i] = 1'b1;
      if (w[i*4 +: 4] == 4'd0) w[i*4 +: 4] = 4'd1;
      run_phase(w, rq, 5, 0);
    end

    // null insertion, then a request raised mid-null
    tick_per = 0;
    apply_reset(16'h2222, 4'b0010);
    model_grant(4'b0010);
    wait_drain(1000);
    wait_pkt_end(1000);
    quiesce();
    nd = nulls_done;
    n = 0;
    while (!null_active && n < 100) begin
      @(negedge clk2); n++;
    end
    chk("null_started", null_active, 1);
    count_ticks(90);
    @(posedge clk2); #1 req = 4'b0010;
    model_grant(4'b0010);
    wait_drain(1000);
    chk("null_count", nulls_done - nd, 1);
    wait_pkt_end(1000);
    quiesce();

    // granted request drops mid-packet
    apply_reset(16'h1111, 4'b0100);
    model_grant(4'b0100);
    wait_drain(1000);
    count_ticks(50);
    @(posedge clk2); #1 req = 4'b0;
    exp_ur++;
    wait_pkt_end(1000);
    repeat (2) @(negedge clk2);
    chk("underrun_count", ur_cnt, exp_ur);

    // reset in the middle of a packet on port 3 (port 0 also holds credit)
    apply_reset(16'h2002, 4'b1000);
    model_grant(4'b1000);
    wait_drain(1000);
    count_ticks(100);
    @(posedge clk2); #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_mux_ctrl", mux_ctrl, 0);
    chk("rst_pulses", {pkt_start, pkt_end, null_active, underrun}, 0);
    weights = 16'h0002;
    req = 4'b0001;
    model_reset(16'h0002);
    exp_q.delete();
    @(posedge clk2); #1 rst_n = 1'b1;
    model_grant(4'b0001);
    lat = 0; seen = 0;
    while (!seen && lat < 10) begin
      @(posedge clk2); lat++;
      @(negedge clk2);
      if (valid != 0) seen = 1;
    end
    chk("rst_grant_latency", lat, 2);
    wait_drain(100);
    wait_pkt_end(1000);
    quiesce();

    repeat (4) @(negedge clk2);
    chk("underrun_total", ur_cnt, exp_ur);
    tb_done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
